// File: rtl/mem_bus_pkg.sv
// Shared encodings, MMIO map and payload types for the memory-side responder.
package mem_bus_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    MW_NONE = 2'd0,
    MW_WORD = 2'd1,
    MW_DMA  = 2'd2,
    MW_BYTE = 2'd3
  } mw_e;

  localparam logic [DATA_W-1:0] ADDR_TIMER_LOAD  = 32'hFFFF_FF00;
  localparam logic [DATA_W-1:0] ADDR_TIMER_CTRL  = 32'hFFFF_FF04;
  localparam logic [DATA_W-1:0] ADDR_TIMER_COUNT = 32'hFFFF_FF08;
  localparam logic [DATA_W-1:0] ADDR_INT_ACK     = 32'hFFFF_FF0C;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AR   = 1;
  localparam int unsigned CTRL_PEND = 2;

  localparam logic [DATA_W-1:0] TIMER_CAUSE_DEF = 32'h0000_0010;

  // One committed register write towards the timer.
  typedef struct packed {
    logic              load_we;
    logic              ctrl_we;
    logic              ack;
    logic [DATA_W-1:0] wdata;
  } tmr_wr_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request signals and interrupt return lines of the memory responder.
interface mem_responder_if;
  import mem_bus_pkg::*;

  logic              Memread;
  logic [1:0]        Memwrite;
  logic [DATA_W-1:0] Addr;
  logic              INTin;
  logic [DATA_W-1:0] INTnum;

  modport master (output Memread, Memwrite, Addr, input INTin, INTnum);
  modport slave  (input Memread, Memwrite, Addr, output INTin, INTnum);
endinterface

// File: rtl/timer_irq.sv
// Memory-mapped down-counting timer with a level interrupt held until acknowledged.
module timer_irq
  import mem_bus_pkg::*;
#(
  parameter logic [DATA_W-1:0] TIMER_CAUSE = TIMER_CAUSE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  tmr_wr_t           wr,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] count_o,
  output logic [2:0]        ctrl_o,
  output logic              int_o,
  output logic [DATA_W-1:0] intnum_o
);

  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              en_q, en_d;
  logic              ar_q, ar_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] intnum_q, intnum_d;

  // Register writes first, then expiry so that expiry beats a same-cycle clear.
  always_comb begin
    load_d   = load_q;
    count_d  = count_q;
    en_d     = en_q;
    ar_d     = ar_q;
    pend_d   = pend_q;
    intnum_d = intnum_q;

    if (wr.ctrl_we) begin
      en_d = wr.wdata[CTRL_EN];
      ar_d = wr.wdata[CTRL_AR];
      if (wr.wdata[CTRL_PEND]) pend_d = 1'b0;
    end
    if (wr.ack) pend_d = 1'b0;

    if (wr.load_we) begin
      load_d  = wr.wdata;
      count_d = wr.wdata;
    end else if (en_q) begin
      if (count_q != '0) begin
        count_d = count_q - DATA_W'(1);
      end else begin
        pend_d = 1'b1;
        if (ar_q) count_d = load_q;
        else if (!wr.ctrl_we) en_d = 1'b0;
      end
    end

    intnum_d = pend_d ? TIMER_CAUSE : '0;
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q   <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      pend_q   <= 1'b0;
      intnum_q <= '0;
    end else begin
      load_q   <= load_d;
      count_q  <= count_d;
      en_q     <= en_d;
      ar_q     <= ar_d;
      pend_q   <= pend_d;
      intnum_q <= intnum_d;
    end
  end

  assign load_o   = load_q;
  assign count_o  = count_q;
  assign ctrl_o   = {pend_q, ar_q, en_q};
  assign int_o    = pend_q;
  assign intnum_o = intnum_q;

endmodule

// File: rtl/mem_responder.sv
// Bus target for the CPU: word RAM, MMIO decode, one-shot write commit and BUS tristate.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned       AW          = 10,
  parameter logic [DATA_W-1:0] TIMER_CAUSE = TIMER_CAUSE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] BUS,
  mem_responder_if.slave    bus_if
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] ram_q [DEPTH];

  logic              mw_idle_q, mw_idle_d;
  logic              sel_ram_c;
  logic [AW-1:0]     idx_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [DATA_W-1:0] wr_word_c;
  logic              commit_c;
  logic              bus_oe_c;
  tmr_wr_t           tmr_wr_c;
  logic [DATA_W-1:0] tmr_load, tmr_count;
  logic [2:0]        tmr_ctrl;
  logic              unused_c;

  assign sel_ram_c = (bus_if.Addr[31:12] == 20'd0);
  assign idx_c     = bus_if.Addr[AW:1];
  assign unused_c  = ^{bus_if.Addr[11:AW+1], bus_if.Addr[0]};

  // Read mux: RAM window, timer registers, everything else reads zero.
  always_comb begin
    rd_data_c = '0;
    if (sel_ram_c)                              rd_data_c = ram_q[idx_c];
    else if (bus_if.Addr == ADDR_TIMER_LOAD)    rd_data_c = tmr_load;
    else if (bus_if.Addr == ADDR_TIMER_CTRL)    rd_data_c = {29'd0, tmr_ctrl};
    else if (bus_if.Addr == ADDR_TIMER_COUNT)   rd_data_c = tmr_count;
  end

  // A request is armed only after Memwrite has been seen idle, so a write
  // already in flight across reset release never commits.
  always_comb begin
    mw_idle_d = (bus_if.Memwrite == MW_NONE);
    commit_c  = mw_idle_q && ((bus_if.Memwrite == MW_WORD) || (bus_if.Memwrite == MW_BYTE));
    wr_word_c = (bus_if.Memwrite == MW_BYTE) ? {rd_data_c[31:16], BUS[15:0]} : BUS;
    bus_oe_c  = bus_if.Memread && (bus_if.Memwrite == MW_NONE);

    tmr_wr_c         = '0;
    tmr_wr_c.wdata   = wr_word_c;
    tmr_wr_c.load_we = commit_c && (bus_if.Addr == ADDR_TIMER_LOAD);
    tmr_wr_c.ctrl_we = commit_c && (bus_if.Addr == ADDR_TIMER_CTRL);
    tmr_wr_c.ack     = commit_c && (bus_if.Addr == ADDR_INT_ACK);
  end

  // Write-edge detect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mw_idle_q <= 1'b0;
    else     mw_idle_q <= mw_idle_d;
  end

  // RAM array, contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (commit_c && sel_ram_c) ram_q[idx_c] <= wr_word_c;
  end

  assign BUS = bus_oe_c ? rd_data_c : 'z;

  timer_irq #(.TIMER_CAUSE(TIMER_CAUSE)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .wr       (tmr_wr_c),
    .load_o   (tmr_load),
    .count_o  (tmr_count),
    .ctrl_o   (tmr_ctrl),
    .int_o    (bus_if.INTin),
    .intnum_o (bus_if.INTnum)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder against a memory-image and timer-period model.
module tb_mem_responder;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tb_data;
  wire  [31:0] bus_w;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [31:0] ram_m [int];

  mem_responder_if bif();

  assign bus_w = (bif.Memwrite != 2'd0) ? tb_data : 32'bz;

  mem_responder #(.AW(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .BUS    (bus_w),
    .bus_if (bif)
  );

  initial forever #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ram_idx(input logic [31:0] addr);
    return int'(addr[10:1]);
  endfunction

  // Write request held for 'hold' cycles; Addr/data change after the first
  // cycle so any re-commit would be visible. Memory image updated once.
  task automatic bus_write(input logic [1:0] mw, input logic [31:0] addr,
                           input logic [31:0] data, input int hold, output int commit_cyc);
    bif.Memread  = 1'b0;
    bif.Memwrite = mw;
    bif.Addr     = addr;
    tb_data      = data;
    cyc();
    commit_cyc = cyc_n;
    for (int i = 1; i < hold; i++) begin
      bif.Addr = addr + 32'd4;
      tb_data  = ~data;
      cyc();
    end
    bif.Memwrite = 2'd0;
    cyc();
    if (addr[31:12] == 20'd0) begin
      if (mw == 2'd1) ram_m[ram_idx(addr)] = data;
      else if (mw == 2'd3) ram_m[ram_idx(addr)] = {ram_m[ram_idx(addr)][31:16], data[15:0]};
    end
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bif.Memread = 1'b1;
    bif.Addr    = addr;
    #1;
    data = bus_w;
    cyc();
    bif.Memread = 1'b0;
  endtask

  task automatic wait_int(input int budget, output int fire_cyc);
    fire_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (bif.INTin === 1'b1) begin
        fire_cyc = cyc_n;
        break;
      end
      cyc();
    end
    if (fire_cyc < 0) chk("int_wait_timeout", {31'd0, bif.INTin}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] pool [8];
    int          c0, f1, f2, lval;

    rst          = 1'b1;
    bif.Memread  = 1'b0;
    bif.Memwrite = 2'd0;
    bif.Addr     = '0;
    tb_data      = '0;
    cyc();
    cyc();

    // Reset state (register reads are combinational, so valid under reset).
    chk("rst_intin", {31'd0, bif.INTin}, 32'd0);
    chk("rst_intnum", bif.INTnum, 32'd0);
    bus_read(ADDR_TIMER_CTRL, rd);  chk("rst_ctrl", rd, 32'd0);
    bus_read(ADDR_TIMER_LOAD, rd);  chk("rst_load", rd, 32'd0);
    bus_read(ADDR_TIMER_COUNT, rd); chk("rst_count", rd, 32'd0);
    rst = 1'b0;
    cyc();

    // WORD write held 3 cycles commits exactly once.
    bus_write(2'd1, 32'h14, 32'h1111_1111, 1, c0);
    bus_write(2'd1, 32'h10, 32'hDEAD_BEEF, 3, c0);
    bus_read(32'h10, rd); chk("word_hold", rd, 32'hDEAD_BEEF);
    bus_read(32'h14, rd); chk("word_once", rd, ram_m[ram_idx(32'h14)]);

    // BYTE write keeps the upper half.
    bus_write(2'd1, 32'h20, 32'hAAAA_BBBB, 1, c0);
    bus_write(2'd3, 32'h20, 32'h1234_5678, 1, c0);
    bus_read(32'h20, rd); chk("byte_merge", rd, 32'hAAAA_5678);

    // DMA: no commit and no drive even with Memread high.
    bus_write(2'd1, 32'h30, 32'hCAFE_F00D, 1, c0);
    bif.Memread  = 1'b1;
    bif.Memwrite = 2'd2;
    bif.Addr     = 32'h30;
    tb_data      = 32'h5555_5555;
    #1;
    chk("dma_no_drive", bus_w, 32'h5555_5555);
    cyc();
    bif.Memwrite = 2'd1;
    bif.Addr     = 32'h34;
    tb_data      = 32'h3C3C_3C3C;
    #1;
    chk("word_no_drive", bus_w, 32'h3C3C_3C3C);
    bif.Memwrite = 2'd0;
    bif.Memread  = 1'b0;
    cyc();
    bus_read(32'h30, rd); chk("dma_unchanged", rd, 32'hCAFE_F00D);

    // Randomized RAM traffic against the memory image.
    for (int k = 0; k < 8; k++) begin
      pool[k] = 32'h100 + 32'(k * 6);
      bus_write(2'd1, pool[k], $urandom, 1, c0);
    end
    for (int n = 0; n < 40; n++) begin
      int          k;
      int          op;
      logic [31:0] a;
      k  = int'($urandom_range(0, 7));
      op = int'($urandom_range(0, 2));
      a  = pool[k];
      if (op == 0)      bus_write(2'd1, a, $urandom, int'($urandom_range(1, 3)), c0);
      else if (op == 1) bus_write(2'd3, a, $urandom, int'($urandom_range(1, 3)), c0);
      else begin
        bus_read(a, rd);
        chk("rand_read", rd, ram_m[ram_idx(a)]);
      end
    end

    bus_read(32'hFFFF_FF40, rd); chk("unmapped", rd, 32'd0);
    bus_read(ADDR_INT_ACK, rd);  chk("ack_reads0", rd, 32'd0);

    // Auto-reload timer: first fire LOAD+1 edges after enable, then every LOAD+1.
    lval = int'($urandom_range(4, 10));
    bus_write(2'd1, ADDR_TIMER_LOAD, 32'(lval), 1, c0);
    bus_read(ADDR_TIMER_COUNT, rd); chk("count_loaded", rd, 32'(lval));
    bus_write(2'd1, ADDR_TIMER_CTRL, 32'd3, 1, c0);
    bus_read(ADDR_TIMER_COUNT, rd); chk("count_dec", rd, 32'(lval - 1));
    wait_int(100, f1);
    chk("fire1_delay", 32'(f1 - c0), 32'(lval + 1));
    chk("intnum_cause", bif.INTnum, 32'h10);
    bus_write(2'd1, ADDR_INT_ACK, 32'd0, 1, c0);
    chk("ack_clears", {31'd0, bif.INTin}, 32'd0);
    chk("ack_intnum", bif.INTnum, 32'd0);
    wait_int(100, f2);
    chk("reload_period", 32'(f2 - f1), 32'(lval + 1));

    // Ack landing on the expiry edge loses to expiry.
    bus_write(2'd1, ADDR_INT_ACK, 32'd0, 1, c0);
    while (cyc_n < f2 + lval) cyc();
    chk("pre_expiry_low", {31'd0, bif.INTin}, 32'd0);
    bus_write(2'd1, ADDR_INT_ACK, 32'd0, 1, c0);
    chk("expiry_vs_ack", {31'd0, bif.INTin}, 32'd1);
    bus_write(2'd1, ADDR_TIMER_CTRL, 32'd7, 1, c0);
    bus_read(ADDR_TIMER_CTRL, rd); chk("ctrl_w1c", rd, 32'd3);

    // LOAD=0 with auto-reload keeps pending asserted through acks.
    bus_write(2'd1, ADDR_TIMER_LOAD, 32'd0, 1, c0);
    bus_write(2'd1, ADDR_INT_ACK, 32'd0, 1, c0);
    for (int i = 0; i < 3; i++) begin
      chk("load0_cont", {31'd0, bif.INTin}, 32'd1);
      cyc();
    end

    // One-shot mode: fires once then disables itself.
    bus_write(2'd1, ADDR_TIMER_CTRL, 32'd0, 1, c0);
    bus_write(2'd1, ADDR_INT_ACK, 32'd0, 1, c0);
    chk("disabled_ack", {31'd0, bif.INTin}, 32'd0);
    bus_write(2'd1, ADDR_TIMER_LOAD, 32'd2, 1, c0);
    bus_write(2'd1, ADDR_TIMER_CTRL, 32'd1, 1, c0);
    wait_int(100, f1);
    chk("oneshot_delay", 32'(f1 - c0), 32'd3);
    bus_read(ADDR_TIMER_CTRL, rd);  chk("oneshot_ctrl", rd, 32'd4);
    bus_read(ADDR_TIMER_COUNT, rd); chk("oneshot_count", rd, 32'd0);

    // Reset in the middle of counting and of a write request.
    bus_write(2'd1, ADDR_INT_ACK, 32'd0, 1, c0);
    bus_write(2'd1, 32'h40, 32'h0101_0101, 1, c0);
    bus_write(2'd1, ADDR_TIMER_LOAD, 32'd20, 1, c0);
    bus_write(2'd1, ADDR_TIMER_CTRL, 32'd3, 1, c0);
    cyc();
    bif.Memwrite = 2'd1;
    bif.Addr     = 32'h40;
    tb_data      = 32'hFFFF_0000;
    rst          = 1'b1;
    #1;
    chk("mid_rst_intin", {31'd0, bif.INTin}, 32'd0);
    chk("mid_rst_intnum", bif.INTnum, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    bif.Memwrite = 2'd0;
    cyc();
    bus_read(32'h40, rd);           chk("rst_no_commit", rd, 32'h0101_0101);
    bus_read(ADDR_TIMER_CTRL, rd);  chk("rst_ctrl2", rd, 32'd0);
    bus_read(ADDR_TIMER_LOAD, rd);  chk("rst_load2", rd, 32'd0);
    bus_read(ADDR_TIMER_COUNT, rd); chk("rst_count2", rd, 32'd0);
    bus_write(2'd1, 32'h40, 32'h0000_0002, 1, c0);
    bus_read(32'h40, rd);           chk("post_rst_write", rd, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
